// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit seven-segment scan controller with per-slot blanking,
// leading-zero suppression and a shadow frame committed only at frame boundaries.
module seg_scan_ctrl #(
    parameter int DIV   = 50000,
    parameter int BLANK = 8
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Load,
    input  logic [15:0] Data,
    input  logic        Lz_en,
    output logic [3:0]  A,
    output logic [3:0]  Dig_n,
    output logic        Frame,
    output logic        Pend
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    typedef enum logic {S_BLANK, S_SHOW} state_t;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    state_t        r_state;
    logic [15:0]   r_disp;
    logic [15:0]   r_shad;
    logic          r_pend;
    logic          w_last;
    logic          w_commit;
    logic [3:0]    w_lead_zero;
    logic          w_blank;
    assign w_last   = r_cnt == CW'(DIV - 1);
    assign w_commit = w_last && r_idx == 2'd3;
    // w_lead_zero[i]: every nibble from digit3 down to digit i is zero
    assign w_lead_zero[3] = r_disp[15:12] == 4'h0;
    assign w_lead_zero[2] = w_lead_zero[3] && r_disp[11:8] == 4'h0;
    assign w_lead_zero[1] = w_lead_zero[2] && r_disp[7:4] == 4'h0;
    assign w_lead_zero[0] = 1'b0;
    assign w_blank = Lz_en && w_lead_zero[r_idx];
    assign A       = r_disp[{r_idx, 2'b00} +: 4];
    assign Dig_n   = (r_state == S_BLANK || w_blank) ? 4'hF : ~(4'b0001 << r_idx);
    assign Frame   = r_cnt == '0 && r_idx == 2'd0;
    assign Pend    = r_pend;
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_cnt   <= '0;
            r_idx   <= 2'd0;
            r_state <= S_BLANK;
            r_disp  <= 16'h0;
            r_shad  <= 16'h0;
            r_pend  <= 1'b0;
        end else begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            if (w_last) begin
                r_idx   <= r_idx + 2'd1;
                r_state <= S_BLANK;
            end else if (r_state == S_BLANK && r_cnt == CW'(BLANK - 1)) begin
                r_state <= S_SHOW;
            end
            // a Load landing on the commit cycle bypasses the shadow
            if (w_commit) begin
                if (Load) begin
                    r_disp <= Data;
                    r_shad <= Data;
                end else if (r_pend) begin
                    r_disp <= r_shad;
                end
                r_pend <= 1'b0;
            end else if (Load) begin
                r_shad <= Data;
                r_pend <= 1'b1;
            end
        end
    end
endmodule
